multichannel_clock_divider: RTL and testbench

Parametrised successor to the single-channel variable clock divider: CHANNELS independent divided clocks from one clk_in, each with a WIDTH-bit divisor. Divisor changes are double-buffered and applied only at a period boundary, so the outputs never glitch. Adds per-channel load strobes, a global phase-align (sync), and a one-cycle tick per output rising edge. Feeds LED PWM/scan timing blocks that need several related rates.

---
 rtl/multichannel_clock_divider.sv | 104 ++++++++++
 tb/tb_multichannel_clock_divider.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_clock_divider.sv
// CHANNELS independent 50%-duty divided clocks from clk_in, each with a
// double-buffered WIDTH-bit divisor applied only at its falling edge.
module multichannel_clock_divider #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic                      sleep,
    input  logic [CHANNELS*WIDTH-1:0] divisor,
    input  logic [CHANNELS-1:0]       load,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       pending
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] active_div_reg, active_div_next;
            logic [WIDTH-1:0] pending_div_reg, pending_div_next;
            logic [WIDTH-1:0] cnt_reg, cnt_next;
            logic             pend_reg, pend_next;
            logic             out_reg, out_next;
            logic             tick_reg, tick_next;
            logic [WIDTH-1:0] slice;
            logic             at_end;

            assign slice  = divisor[gi*WIDTH +: WIDTH];
            assign at_end = (cnt_reg == (active_div_reg - ONE));

            always_comb begin
                active_div_next  = active_div_reg;
                pending_div_next = pending_div_reg;
                cnt_next         = cnt_reg;
                pend_next        = pend_reg;
                out_next         = out_reg;
                tick_next        = 1'b0;

                if (sleep || sync) begin
                    // Phase restart: a fresh load wins over an older pending value
                    cnt_next = '0;
                    out_next = 1'b0;
                    if (load[gi]) begin
                        active_div_next = slice;
                        pend_next       = 1'b0;
                    end else if (pend_reg) begin
                        active_div_next = pending_div_reg;
                        pend_next       = 1'b0;
                    end
                end else if (active_div_reg == '0) begin
                    cnt_next = '0;
                    out_next = 1'b0;
                    if (load[gi]) begin
                        active_div_next = slice;
                    end
                end else begin
                    if (at_end) begin
                        cnt_next  = '0;
                        out_next  = ~out_reg;
                        tick_next = ~out_reg;
                        // Falling edge is the only safe point to swap divisors
                        if (out_reg && pend_reg) begin
                            active_div_next = pending_div_reg;
                            pend_next       = 1'b0;
                        end
                    end else begin
                        cnt_next = cnt_reg + ONE;
                    end
                    if (load[gi]) begin
                        pending_div_next = slice;
                        pend_next        = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_in or negedge reset_n) begin
                if (!reset_n) begin
                    active_div_reg  <= '0;
                    pending_div_reg <= '0;
                    cnt_reg         <= '0;
                    pend_reg        <= 1'b0;
                    out_reg         <= 1'b0;
                    tick_reg        <= 1'b0;
                end else begin
                    active_div_reg  <= active_div_next;
                    pending_div_reg <= pending_div_next;
                    cnt_reg         <= cnt_next;
                    pend_reg        <= pend_next;
                    out_reg         <= out_next;
                    tick_reg        <= tick_next;
                end
            end

            assign clk_out[gi] = out_reg;
            assign tick[gi]    = tick_reg;
            assign pending[gi] = pend_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multichannel_clock_divider.sv
// Directed bench for multichannel_clock_divider: edge timing of each channel
// is recorded by a monitor and compared against hand-derived cycle numbers.
module tb_multichannel_clock_divider;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk_in  = 1'b0;
    logic            reset_n = 1'b0;
    logic            sleep   = 1'b0;
    logic            sync    = 1'b0;
    logic [CH*W-1:0] divisor = '0;
    logic [CH-1:0]   load    = '0;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   pending;

    multichannel_clock_divider #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .sleep   (sleep),
        .divisor (divisor),
        .load    (load),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending)
    );

    always #5 clk_in = ~clk_in;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    int last_rise [CH];
    int last_fall [CH];
    int last_edge [CH];
    int hi_w      [CH];
    int lo_w      [CH];
    int min_w     [CH];
    int rise_cnt  [CH];
    int tick_cnt  [CH];
    int tick_bad  [CH];
    logic [CH-1:0] prev_out = '0;
    bit pend_seen = 0;

    // Edge monitor: cycle number = index of the clk_in rising edge just seen
    always @(posedge clk_in) begin
        cyc = cyc + 1;
        #1;
        for (int i = 0; i < CH; i++) begin
            if (clk_out[i] && !prev_out[i]) begin
                rise_cnt[i]++;
                if (last_fall[i] >= 0) lo_w[i] = cyc - last_fall[i];
                last_rise[i] = cyc;
                if (last_edge[i] >= 0 && (cyc - last_edge[i]) < min_w[i]) min_w[i] = cyc - last_edge[i];
                last_edge[i] = cyc;
            end else if (!clk_out[i] && prev_out[i]) begin
                if (last_rise[i] >= 0) hi_w[i] = cyc - last_rise[i];
                last_fall[i] = cyc;
                if (last_edge[i] >= 0 && (cyc - last_edge[i]) < min_w[i]) min_w[i] = cyc - last_edge[i];
                last_edge[i] = cyc;
            end
            if (tick[i]) tick_cnt[i]++;
            if (tick[i] !== (clk_out[i] && !prev_out[i])) tick_bad[i]++;
        end
        if (pending != '0) pend_seen = 1;
        prev_out = clk_out;
    end

    task automatic init_stats();
        for (int i = 0; i < CH; i++) begin
            last_rise[i] = -1; last_fall[i] = -1; last_edge[i] = -1;
            hi_w[i] = 0; lo_w[i] = 0; min_w[i] = 1000000;
            rise_cnt[i] = 0; tick_cnt[i] = 0; tick_bad[i] = 0;
        end
        prev_out  = clk_out;
        pend_seen = 0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < CH; i++) begin
            rise_cnt[i] = 0; tick_cnt[i] = 0; min_w[i] = 1000000;
        end
        pend_seen = 0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk_in);
    endtask

    // Load is sampled at rising edge e; returns at the following negedge (cyc == e)
    task automatic load_at(input logic [CH-1:0] mask, input logic [CH*W-1:0] dv, input int e);
        wait_cyc(e - 1);
        divisor = dv;
        load    = mask;
        @(negedge clk_in);
        load = '0;
        $display("load mask=%b divisor=%h edge=%0d", mask, dv, e);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        init_stats();
    endtask

    task automatic test_reset();
        int s;
        @(negedge clk_in);
        nvec++; if (clk_out !== '0) begin nerr++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
        nvec++; if (tick !== '0) begin nerr++; $display("FAIL reset_tick: got %b expected 0", tick); end
        nvec++; if (pending !== '0) begin nerr++; $display("FAIL reset_pending: got %b expected 0", pending); end
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        init_stats();
        wait_cyc(cyc + 100);
        s = 0;
        for (int i = 0; i < CH; i++) s += rise_cnt[i] + tick_cnt[i];
        nvec++; if (s != 0) begin nerr++; $display("FAIL idle_activity: got %0d edges/ticks expected 0", s); end
        nvec++; if (pend_seen) begin nerr++; $display("FAIL idle_pending: got 1 expected 0"); end
        nvec++; if (clk_out !== '0) begin nerr++; $display("FAIL idle_clk_out: got %b expected 0", clk_out); end
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_basic_rates();
        int k;
        int dexp [CH] = '{1, 2, 3, 128};
        int rexp [CH] = '{599, 598, 597, 384};
        do_reset();
        k = cyc + 2;
        load_at(4'hF, {8'h80, 8'd3, 8'd2, 8'd1}, k);
        wait_cyc(k + 600);
        for (int i = 0; i < CH; i++) begin
            nvec++; if (hi_w[i] != dexp[i]) begin nerr++; $display("FAIL basic_high ch%0d: got %0d expected %0d", i, hi_w[i], dexp[i]); end
            nvec++; if (lo_w[i] != dexp[i]) begin nerr++; $display("FAIL basic_low ch%0d: got %0d expected %0d", i, lo_w[i], dexp[i]); end
            nvec++; if (last_rise[i] != k + rexp[i]) begin nerr++; $display("FAIL basic_last_rise ch%0d: got %0d expected %0d", i, last_rise[i], k + rexp[i]); end
            nvec++; if (tick_cnt[i] != rise_cnt[i]) begin nerr++; $display("FAIL basic_ticks ch%0d: got %0d expected %0d", i, tick_cnt[i], rise_cnt[i]); end
            nvec++; if (tick_bad[i] != 0) begin nerr++; $display("FAIL basic_tick_align ch%0d: got %0d bad expected 0", i, tick_bad[i]); end
        end
        $display("test_basic_rates done at cycle %0d", cyc);
    endtask

    task automatic test_glitch_free();
        int k;
        do_reset();
        k = cyc + 2;
        load_at(4'h1, 32'h5, k);
        wait_cyc(k + 16);
        clear_counts();
        load_at(4'h1, 32'h2, k + 17);
        nvec++; if (pending[0] !== 1'b1) begin nerr++; $display("FAIL glitch_pend_set: got %b expected 1", pending[0]); end
        wait_cyc(k + 19);
        nvec++; if (pending[0] !== 1'b1 || clk_out[0] !== 1'b1) begin nerr++; $display("FAIL glitch_hold: got pend=%b out=%b expected 1 1", pending[0], clk_out[0]); end
        wait_cyc(k + 20);
        nvec++; if (pending[0] !== 1'b0 || clk_out[0] !== 1'b0) begin nerr++; $display("FAIL glitch_boundary: got pend=%b out=%b expected 0 0", pending[0], clk_out[0]); end
        nvec++; if (hi_w[0] != 5) begin nerr++; $display("FAIL glitch_old_high: got %0d expected 5", hi_w[0]); end
        wait_cyc(k + 30);
        nvec++; if (last_rise[0] != k + 30) begin nerr++; $display("FAIL glitch_new_rise: got %0d expected %0d", last_rise[0], k + 30); end
        nvec++; if (hi_w[0] != 2 || lo_w[0] != 2) begin nerr++; $display("FAIL glitch_new_period: got hi=%0d lo=%0d expected 2 2", hi_w[0], lo_w[0]); end
        nvec++; if (min_w[0] != 2) begin nerr++; $display("FAIL glitch_min_pulse: got %0d expected 2", min_w[0]); end
        nvec++; if (tick_bad[0] != 0) begin nerr++; $display("FAIL glitch_tick_align: got %0d expected 0", tick_bad[0]); end
        $display("test_glitch_free done at cycle %0d", cyc);
    endtask

    task automatic test_overwrite_stop();
        int k;
        do_reset();
        k = cyc + 2;
        load_at(4'h1, 32'h4, k);
        load_at(4'h1, 32'h10, k + 9);
        load_at(4'h1, 32'h3, k + 11);
        nvec++; if (pending[0] !== 1'b1) begin nerr++; $display("FAIL ovw_pending: got %b expected 1", pending[0]); end
        wait_cyc(k + 16);
        nvec++; if (last_fall[0] != k + 16 || pending[0] !== 1'b0) begin nerr++; $display("FAIL ovw_boundary: got fall=%0d pend=%b expected %0d 0", last_fall[0], pending[0], k + 16); end
        wait_cyc(k + 19);
        nvec++; if (last_rise[0] != k + 19 || lo_w[0] != 3) begin nerr++; $display("FAIL ovw_applied: got rise=%0d lo=%0d expected %0d 3", last_rise[0], lo_w[0], k + 19); end
        load_at(4'h1, 32'h0, k + 23);
        nvec++; if (pending[0] !== 1'b1) begin nerr++; $display("FAIL stop_pending: got %b expected 1", pending[0]); end
        wait_cyc(k + 28);
        nvec++; if (last_fall[0] != k + 28 || hi_w[0] != 3 || pending[0] !== 1'b0) begin nerr++; $display("FAIL stop_boundary: got fall=%0d hi=%0d pend=%b expected %0d 3 0", last_fall[0], hi_w[0], pending[0], k + 28); end
        clear_counts();
        wait_cyc(k + 60);
        nvec++; if (rise_cnt[0] != 0 || tick_cnt[0] != 0 || clk_out[0] !== 1'b0) begin nerr++; $display("FAIL stop_idle: got rises=%0d ticks=%0d out=%b expected 0 0 0", rise_cnt[0], tick_cnt[0], clk_out[0]); end
        nvec++; if (pend_seen || tick_bad[0] != 0) begin nerr++; $display("FAIL stop_clean: got pend_seen=%0d tick_bad=%0d expected 0 0", pend_seen, tick_bad[0]); end
        $display("test_overwrite_stop done at cycle %0d", cyc);
    endtask

    task automatic test_sync_sleep();
        int b, s, p, n;
        do_reset();
        b = cyc + 2;
        load_at(4'h1, 32'h0000_0003, b);
        load_at(4'h2, 32'h0000_0300, b + 1);
        s = b + 20;
        wait_cyc(s - 1);
        sync = 1'b1;
        @(negedge clk_in);
        sync = 1'b0;
        $display("sync edge=%0d", s);
        nvec++; if (clk_out[1:0] !== 2'b00) begin nerr++; $display("FAIL sync_low: got %b expected 00", clk_out[1:0]); end
        wait_cyc(s + 2);
        nvec++; if (clk_out[1:0] !== 2'b00) begin nerr++; $display("FAIL sync_still_low: got %b expected 00", clk_out[1:0]); end
        wait_cyc(s + 3);
        nvec++; if (clk_out[1:0] !== 2'b11 || last_rise[0] != s + 3 || last_rise[1] != s + 3) begin nerr++; $display("FAIL sync_aligned: got out=%b r0=%0d r1=%0d expected 11 %0d %0d", clk_out[1:0], last_rise[0], last_rise[1], s + 3, s + 3); end
        p = s + 10;
        wait_cyc(p - 1);
        sleep = 1'b1;
        clear_counts();
        load_at(4'h4, 32'h0002_0000, p + 5);
        wait_cyc(p + 19);
        n = 0;
        for (int i = 0; i < CH; i++) n += rise_cnt[i] + tick_cnt[i];
        nvec++; if (n != 0) begin nerr++; $display("FAIL sleep_activity: got %0d expected 0", n); end
        nvec++; if (clk_out !== '0 || pend_seen) begin nerr++; $display("FAIL sleep_outputs: got out=%b pend_seen=%0d expected 0 0", clk_out, pend_seen); end
        sleep = 1'b0;
        wait_cyc(p + 20);
        nvec++; if (clk_out !== '0) begin nerr++; $display("FAIL wake_low: got %b expected 0", clk_out); end
        wait_cyc(p + 21);
        nvec++; if (clk_out[2] !== 1'b1 || last_rise[2] != p + 21 || rise_cnt[2] != 1) begin nerr++; $display("FAIL wake_ch2: got out=%b rise=%0d n=%0d expected 1 %0d 1", clk_out[2], last_rise[2], rise_cnt[2], p + 21); end
        wait_cyc(p + 22);
        nvec++; if (clk_out[1:0] !== 2'b11) begin nerr++; $display("FAIL wake_ch01: got %b expected 11", clk_out[1:0]); end
        for (int i = 0; i < 3; i++) begin
            nvec++; if (tick_bad[i] != 0) begin nerr++; $display("FAIL sync_tick_align ch%0d: got %0d expected 0", i, tick_bad[i]); end
        end
        $display("test_sync_sleep done at cycle %0d", cyc);
    endtask

    task automatic test_max_divisor();
        int k;
        do_reset();
        k = cyc + 2;
        load_at(4'h8, 32'hFF00_0000, k);
        wait_cyc(k + 254);
        nvec++; if (clk_out[3] !== 1'b0) begin nerr++; $display("FAIL max_pre_rise: got %b expected 0", clk_out[3]); end
        wait_cyc(k + 255);
        nvec++; if (clk_out[3] !== 1'b1 || tick[3] !== 1'b1) begin nerr++; $display("FAIL max_first_rise: got out=%b tick=%b expected 1 1", clk_out[3], tick[3]); end
        wait_cyc(k + 765);
        nvec++; if (last_rise[3] != k + 765) begin nerr++; $display("FAIL max_second_rise: got %0d expected %0d", last_rise[3], k + 765); end
        nvec++; if (hi_w[3] + lo_w[3] != 510 || hi_w[3] != 255) begin nerr++; $display("FAIL max_period: got hi=%0d lo=%0d expected 255 255", hi_w[3], lo_w[3]); end
        nvec++; if (tick_cnt[3] != 2) begin nerr++; $display("FAIL max_ticks: got %0d expected 2", tick_cnt[3]); end
        $display("test_max_divisor done at cycle %0d", cyc);
    endtask

    task automatic test_async_reset();
        int k;
        do_reset();
        k = cyc + 2;
        load_at(4'h3, 32'h0000_0201, k);
        load_at(4'h2, 32'h0000_0300, k + 5);
        wait_cyc(k + 7);
        nvec++; if (clk_out[1:0] !== 2'b11 || pending !== 4'b0010) begin nerr++; $display("FAIL pre_reset: got out=%b pend=%b expected 11 0010", clk_out[1:0], pending); end
        #1 reset_n = 1'b0;
        #1;
        nvec++; if (clk_out !== '0 || tick !== '0 || pending !== '0) begin nerr++; $display("FAIL async_reset: got out=%b tick=%b pend=%b expected 0 0 0", clk_out, tick, pending); end
        @(negedge clk_in);
        reset_n = 1'b1;
        init_stats();
        wait_cyc(cyc + 10);
        nvec++; if (clk_out !== '0 || rise_cnt[0] != 0 || rise_cnt[1] != 0) begin nerr++; $display("FAIL post_reset_idle: got out=%b expected 0", clk_out); end
        $display("test_async_reset done at cycle %0d", cyc);
    endtask

    initial begin
        init_stats();
        test_reset();
        test_basic_rates();
        test_glitch_free();
        test_overwrite_stop();
        test_sync_sleep();
        test_max_divisor();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
